reg_lock_port_agent: RTL and testbench
======================================

Name: reg_lock_port_agent

Overview:
- Per-port client FSM sitting directly upstream of one port of the locked physical register.
- Turns a single read or write operation from the issue stage into the lock port protocol: request, wait for grant, sample/commit, release.
- Returns read data, or accepts write data, on simple valid/ready handshakes.
- One instance per register port; its lock-side outputs wire 1:1 to that port's req_read/req_write/req_issue_id/release_lock/write_commit/wdata, and it consumes that port's grant plus the shared rdata.

Parameters:
ID_WIDTH, 4, width of issue id forwarded to the lock.
TIMEOUT, 64, max ACQUIRE cycles before giving up; 0 disables the timeout.
CNT_WIDTH, 16, width of the saturating stall counter.

Ports:
clk  input  1  clock
rst_n  input  1  reset; asynchronous, active-low
op_valid  input  1  issue stage presents an operation
op_ready  output  1  agent accepts an operation (high only in IDLE)
op_write  input  1  1 = write op, 0 = read op
op_issue_id  input  ID_WIDTH  issue id of the operation
abort  input  1  flush current operation
wr_valid  input  1  write data available
wr_ready  output  1  write data accepted this cycle
wr_data  input  32  data to commit
rd_valid  output  1  one-cycle pulse: rd_data valid
rd_data  output  32  captured register value
timeout_err  output  1  one-cycle pulse: ACQUIRE timed out
busy  output  1  state != IDLE
stall_cnt  output  CNT_WIDTH  total cycles spent in ACQUIRE without grant, saturating
req_read  output  1  to lock port
req_write  output  1  to lock port
req_issue_id  output  ID_WIDTH  to lock port
release_lock  output  1  to lock port
write_commit  output  1  to lock port
wdata  output  32  to lock port
grant  input  1  from lock port; combinational (same-cycle) grant
rdata  input  32  register contents, combinational

Behaviour:
- Reset values: state IDLE; rd_valid, timeout_err, rd_data, stall_cnt, the latched op (write flag, id), and the wait counter all 0.
- Reset is asynchronous at any point. A lock held at reset is not released by the agent; the lock itself resets alongside.
- Lock-side outputs are combinational from state and registered op fields. Outside the states listed below they are 0.
- req_issue_id = latched id whenever req_read or req_write is high, else 0.
- States:
  - IDLE:
    - op_ready=1.
    - op_valid latches op_write and op_issue_id, clears the wait counter, and moves to ACQUIRE.
    - abort in IDLE is ignored.
  - ACQUIRE:
    - Drives req_read=!wr_flag, req_write=wr_flag.
    - If grant and read: rd_data<=rdata (same-cycle flash sample), rd_valid pulses the next cycle, then RELEASE.
    - If grant and write: go to HOLD_W.
    - If no grant: wait counter +1 and stall_cnt +1 (saturating at all-ones).
    - If TIMEOUT!=0 and the wait counter reaches TIMEOUT-1 with no grant: timeout_err pulses the next cycle, go to IDLE, no release issued.
    - abort without grant: go to IDLE, no release.
    - abort with grant in the same cycle: grant wins. Read completes normally; write goes to RELEASE without commit.
  - HOLD_W:
    - Keeps req_write=1.
    - wr_ready = grant.
    - If wr_valid && grant: write_commit=1 and wdata=wr_data in that cycle, then RELEASE.
    - abort: go to RELEASE, no commit (abort has priority over wr_valid).
    - If grant drops in HOLD_W: stay, wr_ready=0, no commit.
    - No timeout in HOLD_W.
  - RELEASE:
    - release_lock=1 for exactly one cycle; req_read, req_write, write_commit all 0.
    - Then IDLE. abort is ignored.
- Latency:
  - Uncontended read: op accepted at cycle T; grant at T+1; rd_valid at T+2; release_lock at T+2; op_ready at T+3.
  - Uncontended write: wr_data accepted at the first HOLD_W cycle at earliest; release the following cycle.
- Only one operation is ever in flight. A new op is never accepted until back in IDLE.
- wdata = wr_data only while write_commit=1, else 0.

Test Plan:
- Read, uncontended: reg holds 0xDEADBEEF, op_valid read id=3 at T, grant immediate -> req_read=1, req_issue_id=3 at T+1; rd_valid=1, rd_data=0xDEADBEEF at T+2; release_lock=1 at T+2 only; op_ready=1 at T+3; stall_cnt=0.
- Write, delayed data: op write id=5, grant immediate, wr_valid asserted 3 cycles later with 0x12345678 -> req_write held for 4 cycles; write_commit high for exactly one cycle with wdata=0x12345678; release_lock pulse the next cycle.
- Contended acquire: grant withheld for 7 cycles, then given on a read -> stall_cnt=7; read completes normally; no timeout_err.
- Timeout: TIMEOUT=4, grant never given -> req_read drops after 4 cycles; timeout_err pulses once; no release_lock; back in IDLE with op_ready=1.
- Abort:
  - During ACQUIRE without grant -> IDLE, no release.
  - During HOLD_W while wr_valid=1 -> write_commit stays 0; release_lock pulses once.
- Reset mid-op: rst_n pulled low in HOLD_W -> all outputs 0 immediately (asynchronously); after deassertion, state IDLE, stall_cnt=0.

Source files
------------

// File: rtl/reg_lock_port_agent.sv
// reg_lock_port_agent
//   Client-side FSM for one port of the locked physical register. It takes a
//   single read or write operation from the issue stage and runs it through
//   the lock protocol: request, wait for grant, sample or commit, release.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   op_valid/op_ready     operation handshake (op_ready high only in IDLE)
//   op_write, op_issue_id operation type (1 = write) and issue id
//   abort                 flush the operation in flight
//   wr_valid/wr_ready     write-data handshake, wr_data is the commit value
//   rd_valid, rd_data     one-cycle read-return pulse and captured value
//   timeout_err           one-cycle pulse when acquisition times out
//   busy                  agent is not idle
//   stall_cnt             saturating count of ungranted acquire cycles
//   req_read, req_write, req_issue_id, release_lock, write_commit, wdata
//                         lock-port request side (combinational)
//   grant, rdata          lock-port grant and register contents (combinational)
module reg_lock_port_agent #(
  parameter int unsigned ID_WIDTH  = 4,
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic                 op_write,
  input  logic [ID_WIDTH-1:0]  op_issue_id,
  input  logic                 abort,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [31:0]          wr_data,
  output logic                 rd_valid,
  output logic [31:0]          rd_data,
  output logic                 timeout_err,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic                 req_read,
  output logic                 req_write,
  output logic [ID_WIDTH-1:0]  req_issue_id,
  output logic                 release_lock,
  output logic                 write_commit,
  output logic [31:0]          wdata,
  input  logic                 grant,
  input  logic [31:0]          rdata
);

  localparam int unsigned WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT == 0) ? '0 : WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACQUIRE,
    S_HOLD_W,
    S_RELEASE
  } state_e;

  state_e                 state_q, state_d;
  logic                   wr_flag_q, wr_flag_d;
  logic [ID_WIDTH-1:0]    id_q, id_d;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic [31:0]            rd_data_q, rd_data_d;
  logic                   rd_valid_q, rd_valid_d;
  logic                   timeout_err_q, timeout_err_d;
  logic [CNT_WIDTH-1:0]   stall_q, stall_d;
  logic                   timeout_hit;

  // Last permitted ungranted acquire cycle; a zero TIMEOUT never fires.
  assign timeout_hit = (TIMEOUT != 0) && (wait_q == WAIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      wr_flag_q     <= 1'b0;
      id_q          <= '0;
      wait_q        <= '0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      stall_q       <= '0;
    end else begin
      state_q       <= state_d;
      wr_flag_q     <= wr_flag_d;
      id_q          <= id_d;
      wait_q        <= wait_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
      timeout_err_q <= timeout_err_d;
      stall_q       <= stall_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wr_flag_d     = wr_flag_q;
    id_d          = id_q;
    wait_d        = wait_q;
    rd_data_d     = rd_data_q;
    rd_valid_d    = 1'b0;
    timeout_err_d = 1'b0;
    stall_d       = stall_q;

    op_ready      = 1'b0;
    wr_ready      = 1'b0;
    req_read      = 1'b0;
    req_write     = 1'b0;
    release_lock  = 1'b0;
    write_commit  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          wr_flag_d = op_write;
          id_d      = op_issue_id;
          wait_d    = '0;
          state_d   = S_ACQUIRE;
        end
      end

      S_ACQUIRE: begin
        req_read  = !wr_flag_q;
        req_write = wr_flag_q;
        if (grant) begin
          // Grant beats a same-cycle abort; an aborted write skips the commit.
          if (!wr_flag_q) begin
            rd_data_d  = rdata;
            rd_valid_d = 1'b1;
            state_d    = S_RELEASE;
          end else begin
            state_d = abort ? S_RELEASE : S_HOLD_W;
          end
        end else begin
          wait_d  = wait_q + 1'b1;
          stall_d = (stall_q == '1) ? stall_q : stall_q + 1'b1;
          // Nothing is held without a grant, so neither exit releases.
          if (abort) begin
            state_d = S_IDLE;
          end else if (timeout_hit) begin
            timeout_err_d = 1'b1;
            state_d       = S_IDLE;
          end
        end
      end

      S_HOLD_W: begin
        req_write = 1'b1;
        wr_ready  = grant;
        if (abort) begin
          state_d = S_RELEASE;
        end else if (wr_valid && grant) begin
          write_commit = 1'b1;
          state_d      = S_RELEASE;
        end
      end

      S_RELEASE: begin
        release_lock = 1'b1;
        state_d      = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy         = (state_q != S_IDLE);
  assign req_issue_id = (req_read || req_write) ? id_q : '0;
  assign wdata        = write_commit ? wr_data : '0;
  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_data_q;
  assign timeout_err  = timeout_err_q;
  assign stall_cnt    = stall_q;

endmodule

// File: tb/tb_reg_lock_port_agent.sv
module tb_reg_lock_port_agent;

  localparam int unsigned IDW = 4;
  localparam int          TMO = 8;
  localparam int unsigned CW  = 6;
  localparam int          SAT = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            op_valid, op_ready, op_write, abort;
  logic            wr_valid, wr_ready, rd_valid, timeout_err, busy;
  logic            req_read, req_write, release_lock, write_commit, grant;
  logic [IDW-1:0]  op_issue_id, req_issue_id;
  logic [31:0]     wr_data, rd_data, wdata, rdata;
  logic [CW-1:0]   stall_cnt;

  always #5 clk = ~clk;

  reg_lock_port_agent #(
    .ID_WIDTH (IDW),
    .TIMEOUT  (TMO),
    .CNT_WIDTH(CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_write    (op_write),
    .op_issue_id (op_issue_id),
    .abort       (abort),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .timeout_err (timeout_err),
    .busy        (busy),
    .stall_cnt   (stall_cnt),
    .req_read    (req_read),
    .req_write   (req_write),
    .req_issue_id(req_issue_id),
    .release_lock(release_lock),
    .write_commit(write_commit),
    .wdata       (wdata),
    .grant       (grant),
    .rdata       (rdata)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  int          model_stall = 0;
  bit          rdata_fix = 1'b0;
  logic [31:0] rdata_fix_val = '0;

  logic           r_rq_rd [64];
  logic           r_rq_wr [64];
  logic           r_rel   [64];
  logic           r_cmt   [64];
  logic           r_rv    [64];
  logic           r_tmo   [64];
  logic           r_rdy   [64];
  logic [31:0]    r_wdata [64];
  logic [31:0]    r_rddat [64];
  logic [IDW-1:0] r_id    [64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive_idle();
    op_valid    = 1'b0;
    op_write    = 1'b0;
    op_issue_id = '0;
    abort       = 1'b0;
    wr_valid    = 1'b0;
    wr_data     = '0;
    grant       = 1'b0;
    rdata       = '0;
  endtask

  // One operation, planned as: grant arrives on acquire cycle g (g >= TMO: never),
  // abort on acquire cycle ab (-1: none), write grant low for the first k hold
  // cycles, wr_valid from hold cycle dv, abort on hold cycle ah (-1: none).
  // Cycle t=0 is the accept cycle. Expected results come from the plan alone.
  task automatic run_op(input bit wr, input logic [IDW-1:0] id, input int g, input int ab,
                        input int k, input int dv, input int ah, input logic [31:0] wd);
    int A, H, R, stall, total, c, commit_t;
    bit granted, timed, commit_exp;
    logic [31:0] exp_rd, got_wd, got_rd;
    logic [CW-1:0] last_stall;
    int n_rqrd, n_rqwr, n_rel, n_cmt, n_rv, n_tmo, n_busy, n_wrrdy, id_err, wd_err;
    exp_rd = '0; got_wd = '0; got_rd = '0; last_stall = '0;
    n_rqrd = 0; n_rqwr = 0; n_rel = 0; n_cmt = 0; n_rv = 0; n_tmo = 0;
    n_busy = 0; n_wrrdy = 0; id_err = 0; wd_err = 0;

    if (ab >= 0 && ab < g) begin
      A = ab + 1; stall = ab + 1; granted = 1'b0; timed = 1'b0;
    end else if (g >= TMO) begin
      A = TMO; stall = TMO; granted = 1'b0; timed = 1'b1;
    end else begin
      A = g + 1; stall = g; granted = 1'b1; timed = 1'b0;
    end
    H = 0; commit_exp = 1'b0; commit_t = -1;
    if (granted && wr && ab != g) begin
      c = (k > dv) ? k : dv;
      if (ah >= 0 && ah <= c) H = ah + 1;
      else begin H = c + 1; commit_exp = 1'b1; commit_t = A + c + 1; end
    end
    R = granted ? 1 : 0;
    total = A + H + R;

    for (int t = 0; t <= total + 1; t++) begin
      rdata = rdata_fix ? rdata_fix_val : $urandom;
      if (t == 0) begin
        op_valid = 1'b1; op_write = wr; op_issue_id = id;
        abort = 1'($urandom_range(0, 1)); grant = 1'b0;
        wr_valid = 1'($urandom_range(0, 1)); wr_data = $urandom;
      end else begin
        op_valid = 1'($urandom_range(0, 1)); op_write = 1'($urandom_range(0, 1));
        op_issue_id = IDW'($urandom); wr_data = $urandom;
        wr_valid = 1'($urandom_range(0, 1)); abort = 1'b0; grant = 1'b0;
        if (t <= A) begin
          grant = ((t - 1) == g);
          abort = (ab >= 0 && (t - 1) == ab);
          if ((t - 1) == g && !wr) exp_rd = rdata;
        end else if (t <= A + H) begin
          grant    = ((t - A - 1) >= k);
          abort    = (ah >= 0 && (t - A - 1) == ah);
          wr_valid = ((t - A - 1) >= dv);
          if (wr_valid) wr_data = wd;
        end else if (t == total && R == 1) begin
          grant = 1'($urandom_range(0, 1));
          abort = 1'($urandom_range(0, 1));
        end else begin
          op_valid = 1'b0; wr_valid = 1'b0;
        end
      end
      @(negedge clk);
      r_rq_rd[t] = req_read;  r_rq_wr[t] = req_write; r_rel[t] = release_lock;
      r_cmt[t]   = write_commit; r_rv[t] = rd_valid; r_tmo[t] = timeout_err;
      r_rdy[t]   = op_ready; r_wdata[t] = wdata; r_rddat[t] = rd_data; r_id[t] = req_issue_id;
      if (req_read) n_rqrd++;
      if (req_write) n_rqwr++;
      if (release_lock) n_rel++;
      if (write_commit) begin n_cmt++; got_wd = wdata; end
      if (!write_commit && wdata != '0) wd_err++;
      if (rd_valid) begin n_rv++; got_rd = rd_data; end
      if (timeout_err) n_tmo++;
      if (busy) n_busy++;
      if (wr_ready) n_wrrdy++;
      if ((req_read || req_write) ? (req_issue_id != id) : (req_issue_id != '0)) id_err++;
      last_stall = stall_cnt;
      @(posedge clk); #1;
    end
    drive_idle();

    model_stall = (model_stall + stall > SAT) ? SAT : model_stall + stall;
    chk("op_ready_accept", 32'(r_rdy[0]), 32'd1);
    chk("busy_cycles", n_busy, total);
    chk("op_ready_back", 32'(r_rdy[total + 1]), 32'd1);
    chk("req_read_cycles", n_rqrd, wr ? 0 : A);
    chk("req_write_cycles", n_rqwr, wr ? A + H : 0);
    chk("issue_id", id_err, 0);
    chk("release_cnt", n_rel, R);
    if (R == 1) chk("release_pos", 32'(r_rel[total]), 32'd1);
    chk("commit_cnt", n_cmt, commit_exp ? 1 : 0);
    if (commit_exp) begin
      chk("commit_pos", 32'(r_cmt[commit_t]), 32'd1);
      chk("commit_data", got_wd, wd);
    end
    chk("wdata_gate", wd_err, 0);
    chk("rd_valid_cnt", n_rv, (granted && !wr) ? 1 : 0);
    if (granted && !wr) begin
      chk("rd_valid_pos", 32'(r_rv[A + 1]), 32'd1);
      chk("rd_data", got_rd, exp_rd);
    end
    chk("timeout_cnt", n_tmo, timed ? 1 : 0);
    if (timed) chk("timeout_pos", 32'(r_tmo[A + 1]), 32'd1);
    chk("wr_ready_cycles", n_wrrdy, (H > k) ? H - k : 0);
    chk("stall_cnt", 32'(last_stall), model_stall);
  endtask

  initial begin
    drive_idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_op_ready", 32'(op_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_req", 32'({req_read, req_write, release_lock, write_commit}), 32'd0);
    chk("rst_req_id", 32'(req_issue_id), 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    @(posedge clk); #1;

    // Uncontended read of 0xDEADBEEF, id 3.
    rdata_fix = 1'b1; rdata_fix_val = 32'hDEADBEEF;
    run_op(1'b0, 4'd3, 0, -1, 0, 0, -1, 32'h0);
    rdata_fix = 1'b0;
    chk("rd_req_t1", 32'(r_rq_rd[1]), 32'd1);
    chk("rd_id_t1", 32'(r_id[1]), 32'd3);
    chk("rd_valid_t2", 32'(r_rv[2]), 32'd1);
    chk("rd_data_t2", r_rddat[2], 32'hDEADBEEF);
    chk("rd_release_t2", 32'(r_rel[2]), 32'd1);
    chk("rd_ready_t3", 32'(r_rdy[3]), 32'd1);

    // Write, data arriving three cycles after the grant.
    run_op(1'b1, 4'd5, 0, -1, 0, 2, -1, 32'h12345678);
    chk("wr_commit_t4", 32'(r_cmt[4]), 32'd1);
    chk("wr_wdata_t4", r_wdata[4], 32'h12345678);
    chk("wr_release_t5", 32'(r_rel[5]), 32'd1);

    run_op(1'b0, 4'd9, 7, -1, 0, 0, -1, 32'h0);                 // contended read
    run_op(1'b0, 4'd2, 99, -1, 0, 0, -1, 32'h0);                // timeout
    chk("tmo_ready_back", 32'(r_rdy[TMO + 1]), 32'd1);
    run_op(1'b1, 4'd6, 5, 2, 0, 0, -1, 32'h0);                  // abort in acquire
    run_op(1'b1, 4'd1, 0, -1, 0, 0, 0, 32'hCAFEF00D);           // abort in hold with data
    run_op(1'b0, 4'd4, 3, 3, 0, 0, -1, 32'h0);                  // abort + grant, read
    run_op(1'b1, 4'd8, 2, 2, 0, 0, -1, 32'h0BADF00D);           // abort + grant, write
    run_op(1'b1, 4'hF, 1, -1, 3, 1, -1, 32'h0F0F1234);          // grant low early in hold

    // Asynchronous reset while holding a write.
    op_valid = 1'b1; op_write = 1'b1; op_issue_id = 4'd7;
    @(posedge clk); #1;
    op_valid = 1'b0; grant = 1'b1;
    @(posedge clk); #1;
    wr_valid = 1'b1; wr_data = 32'hA5A50001;
    #1;
    chk("prerst_commit", 32'(write_commit), 32'd1);
    chk("prerst_stall", 32'(stall_cnt), model_stall);
    rst_n = 1'b0;
    #1;
    chk("midrst_commit", 32'(write_commit), 32'd0);
    chk("midrst_wdata", wdata, 32'd0);
    chk("midrst_req", 32'({req_read, req_write, release_lock, wr_ready, busy}), 32'd0);
    chk("midrst_stall", 32'(stall_cnt), 32'd0);
    @(posedge clk); #1;
    drive_idle();
    rst_n = 1'b1;
    model_stall = 0;
    #1;
    chk("postrst_ready", 32'(op_ready), 32'd1);
    chk("postrst_stall", 32'(stall_cnt), 32'd0);
    @(posedge clk); #1;

    // Random operations; the stall counter saturates along the way.
    for (int n = 0; n < 40; n++) begin
      int g, ab, k, dv, ah, lim;
      g   = ($urandom_range(0, 4) == 0) ? 50 : int'($urandom_range(0, TMO - 1));
      lim = (g < TMO - 2) ? g : TMO - 2;
      ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, lim)) : -1;
      k   = int'($urandom_range(0, 2));
      dv  = int'($urandom_range(0, 3));
      ah  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_op(1'($urandom_range(0, 1)), IDW'($urandom), g, ab, k, dv, ah, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
